// File: rtl/game_stats_bcd.sv
// Game-statistics accumulator for the status-text renderer.
// Keeps score, lines and level as 6-digit packed BCD; score scales with level by repeated BCD addition.
module game_stats_bcd #(
  parameter int LINES_PER_LEVEL = 10,
  parameter int START_LEVEL     = 0,
  parameter int MAX_LEVEL       = 29
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        new_game_i,
  input  logic        lines_valid_i,
  input  logic [2:0]  lines_cnt_i,
  output logic        ready_o,
  output logic [23:0] score_o,
  output logic [23:0] lines_o,
  output logic [23:0] level_o,
  output logic        level_up_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD_LINES,
    S_ADD_SCORE,
    S_LVL_CHK
  } state_t;

  localparam logic [23:0] LP_START_BCD = {16'h0000, 4'(START_LEVEL / 10), 4'(START_LEVEL % 10)};
  localparam logic [6:0]  LP_START_BIN = 7'(START_LEVEL);
  localparam logic [6:0]  LP_MAX_BIN   = 7'(MAX_LEVEL);
  localparam logic [6:0]  LP_LPL       = 7'(LINES_PER_LEVEL);
  localparam logic [23:0] LP_BCD_MAX   = 24'h999999;

  // Per-digit carry-propagating add; a carry out of the top digit saturates.
  function automatic logic [23:0] bcd_add(input logic [23:0] a, input logic [23:0] b);
    logic [4:0]  d;
    logic        c;
    logic [23:0] s;
    c = 1'b0;
    s = '0;
    for (int i = 0; i < 6; i++) begin
      d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, c};
      if (d > 5'd9) begin
        d = d + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      s[4*i +: 4] = d[3:0];
    end
    return c ? LP_BCD_MAX : s;
  endfunction

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_n;
  logic [23:0] r_base;
  logic [6:0]  r_rep_cnt;
  logic [6:0]  r_level_bin;
  logic [6:0]  r_lines_acc;
  logic [23:0] r_score;
  logic [23:0] r_lines;
  logic [23:0] r_level;
  logic        r_ready;
  logic        r_level_up;

  logic [2:0]  w_n_clamp;
  logic [23:0] w_base;
  logic        w_accept;
  logic        w_lvl_wrap;
  logic        w_lvl_inc;
  logic [23:0] w_score_sum;
  logic [23:0] w_lines_sum;
  logic [23:0] w_level_sum;

  assign w_n_clamp   = (lines_cnt_i > 3'd4) ? 3'd4 : lines_cnt_i;
  assign w_accept    = lines_valid_i && r_ready && (w_n_clamp != 3'd0);
  assign w_lvl_wrap  = (r_lines_acc >= LP_LPL);
  assign w_lvl_inc   = w_lvl_wrap && (r_level_bin < LP_MAX_BIN);
  assign w_score_sum = bcd_add(r_score, r_base);
  assign w_lines_sum = bcd_add(r_lines, {21'h000000, r_n});
  assign w_level_sum = bcd_add(r_level, 24'h000001);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_base = 24'h000000;
    case (w_n_clamp)
      3'd1:    w_base = 24'h000040;
      3'd2:    w_base = 24'h000100;
      3'd3:    w_base = 24'h000300;
      3'd4:    w_base = 24'h001200;
      default: w_base = 24'h000000;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (w_accept) w_state_next = S_ADD_LINES;
      S_ADD_LINES: w_state_next = S_ADD_SCORE;
      S_ADD_SCORE: if (r_rep_cnt == 7'd0) w_state_next = S_LVL_CHK;
      S_LVL_CHK:   w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
    if (new_game_i) w_state_next = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n         <= 3'd0;
      r_base      <= 24'h000000;
      r_rep_cnt   <= 7'd0;
      r_level_bin <= LP_START_BIN;
      r_lines_acc <= 7'd0;
      r_score     <= 24'h000000;
      r_lines     <= 24'h000000;
      r_level     <= LP_START_BCD;
      r_ready     <= 1'b1;
      r_level_up  <= 1'b0;
    end else if (new_game_i) begin
      r_n         <= 3'd0;
      r_base      <= 24'h000000;
      r_rep_cnt   <= 7'd0;
      r_level_bin <= LP_START_BIN;
      r_lines_acc <= 7'd0;
      r_score     <= 24'h000000;
      r_lines     <= 24'h000000;
      r_level     <= LP_START_BCD;
      r_ready     <= 1'b1;
      r_level_up  <= 1'b0;
    end else begin
      r_ready    <= (w_state_next == S_IDLE);
      r_level_up <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_n    <= w_n_clamp;
            r_base <= w_base;
          end
        end
        S_ADD_LINES: begin
          r_lines     <= w_lines_sum;
          r_lines_acc <= r_lines_acc + {4'b0000, r_n};
          r_rep_cnt   <= r_level_bin;
        end
        S_ADD_SCORE: begin
          r_score <= w_score_sum;
          if (r_rep_cnt != 7'd0) r_rep_cnt <= r_rep_cnt - 7'd1;
        end
        S_LVL_CHK: begin
          // At MAX_LEVEL the accumulator still wraps; only the level and pulse are suppressed.
          if (w_lvl_wrap) begin
            r_lines_acc <= r_lines_acc - LP_LPL;
            if (w_lvl_inc) begin
              r_level_bin <= r_level_bin + 7'd1;
              r_level     <= w_level_sum;
              r_level_up  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o    = r_ready;
  assign score_o    = r_score;
  assign lines_o    = r_lines;
  assign level_o    = r_level;
  assign level_up_o = r_level_up;

endmodule

// File: tb/tb_game_stats_bcd.sv
// Bench for game_stats_bcd: two instances (default parameters and a level-2/max-2 build)
// checked against an integer scoring model.
module tb_game_stats_bcd;

  localparam int A_LPL = 10, A_START = 0, A_MAX = 29;
  localparam int B_LPL = 4,  B_START = 2, B_MAX = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        new_game [2];
  logic        valid    [2];
  logic [2:0]  cnt_in   [2];
  logic        ready    [2];
  logic        lvl_up   [2];
  logic [23:0] score    [2];
  logic [23:0] lines    [2];
  logic [23:0] level    [2];

  int p_lpl   [2] = '{A_LPL, B_LPL};
  int p_start [2] = '{A_START, B_START};
  int p_max   [2] = '{A_MAX, B_MAX};

  int m_score [2];
  int m_lines [2];
  int m_level [2];
  int m_acc   [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  game_stats_bcd #(.LINES_PER_LEVEL(A_LPL), .START_LEVEL(A_START), .MAX_LEVEL(A_MAX)) dut_a (
    .clk(clk), .rst_n(rst_n), .new_game_i(new_game[0]), .lines_valid_i(valid[0]),
    .lines_cnt_i(cnt_in[0]), .ready_o(ready[0]), .score_o(score[0]), .lines_o(lines[0]),
    .level_o(level[0]), .level_up_o(lvl_up[0])
  );

  game_stats_bcd #(.LINES_PER_LEVEL(B_LPL), .START_LEVEL(B_START), .MAX_LEVEL(B_MAX)) dut_b (
    .clk(clk), .rst_n(rst_n), .new_game_i(new_game[1]), .lines_valid_i(valid[1]),
    .lines_cnt_i(cnt_in[1]), .ready_o(ready[1]), .score_o(score[1]), .lines_o(lines[1]),
    .level_o(level[1]), .level_up_o(lvl_up[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int          t;
    t = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model_reset(input int idx);
    m_score[idx] = 0;
    m_lines[idx] = 0;
    m_level[idx] = p_start[idx];
    m_acc[idx]   = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input int idx, input string tag);
    check({tag, "_score"}, 32'(score[idx]), 32'(to_bcd(m_score[idx])));
    check({tag, "_lines"}, 32'(lines[idx]), 32'(to_bcd(m_lines[idx])));
    check({tag, "_level"}, 32'(level[idx]), 32'(to_bcd(m_level[idx])));
    check({tag, "_ready"}, 32'(ready[idx]), 32'd1);
    check({tag, "_lvlup"}, 32'(lvl_up[idx]), 32'd0);
  endtask

  task automatic do_new_game(input int idx);
    new_game[idx] = 1'b1;
    tick();
    new_game[idx] = 1'b0;
    model_reset(idx);
    check_state(idx, "newgame");
  endtask

  // One event; optionally pokes lines_valid_i while busy, which must be ignored.
  task automatic send(input int idx, input logic [2:0] cnt, input bit poke, input string tag);
    int n, lvl, busy, pulses, exp_busy, exp_pulse, base;
    n = (cnt > 3'd4) ? 4 : int'(cnt);
    check({tag, "_ready_pre"}, 32'(ready[idx]), 32'd1);
    valid[idx]  = 1'b1;
    cnt_in[idx] = cnt;
    tick();
    valid[idx] = 1'b0;
    busy   = 0;
    pulses = 0;
    while (!ready[idx] && busy < 300) begin
      if (lvl_up[idx]) pulses++;
      if (poke && busy == 1) begin
        valid[idx]  = 1'b1;
        cnt_in[idx] = 3'($urandom_range(1, 7));
      end else begin
        valid[idx] = 1'b0;
      end
      busy++;
      tick();
    end
    valid[idx] = 1'b0;
    if (lvl_up[idx]) pulses++;
    tick();
    if (lvl_up[idx]) pulses++;

    lvl       = m_level[idx];
    exp_busy  = 0;
    exp_pulse = 0;
    if (n > 0) begin
      case (n)
        1:       base = 40;
        2:       base = 100;
        3:       base = 300;
        default: base = 1200;
      endcase
      exp_busy     = lvl + 3;
      m_lines[idx] = (m_lines[idx] + n > 999999) ? 999999 : m_lines[idx] + n;
      m_score[idx] = (m_score[idx] + base * (lvl + 1) > 999999) ? 999999
                                                               : m_score[idx] + base * (lvl + 1);
      m_acc[idx] += n;
      if (m_acc[idx] >= p_lpl[idx]) begin
        m_acc[idx] -= p_lpl[idx];
        if (m_level[idx] < p_max[idx]) begin
          m_level[idx]++;
          exp_pulse = 1;
        end
      end
    end
    check({tag, "_busy"},   32'(busy),   32'(exp_busy));
    check({tag, "_pulses"}, 32'(pulses), 32'(exp_pulse));
    check_state(idx, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      new_game[k] = 1'b0;
      valid[k]    = 1'b0;
      cnt_in[k]   = 3'd0;
      model_reset(k);
    end
    repeat (2) tick();
    check_state(0, "rst_a");
    check_state(1, "rst_b");
    rst_n = 1'b1;
    tick();

    // Async reset in the middle of ADD_SCORE on the level-2 instance.
    valid[1]  = 1'b1;
    cnt_in[1] = 3'd4;
    tick();
    valid[1] = 1'b0;
    check("t1_busy", 32'(ready[1]), 32'd0);
    tick();
    tick();
    check("t1_partial", 32'(score[1]), 32'h001200);
    rst_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    check_state(1, "t1_async");
    #3;
    rst_n = 1'b1;
    tick();
    check("t1_ready", 32'(ready[1]), 32'd1);

    // Single line at level 0.
    send(0, 3'd1, 1'b0, "t2");
    check("t2_score_const", 32'(score[0]), 32'h000040);

    // Level-up from a fresh game, with an ignored busy strobe.
    do_new_game(0);
    send(0, 3'd4, 1'b1, "t4a");
    send(0, 3'd4, 1'b0, "t4b");
    send(0, 3'd2, 1'b0, "t4c");
    check("t4_score_const", 32'(score[0]), 32'h002500);
    check("t4_lines_const", 32'(lines[0]), 32'h000010);
    check("t4_level_const", 32'(level[0]), 32'h000001);
    send(0, 3'd0, 1'b0, "t4_zero");
    send(0, 3'd6, 1'b0, "t4_clamp");

    // Tetris at level 2.
    send(1, 3'd4, 1'b0, "t3");
    check("t3_score_const", 32'(score[1]), 32'h003600);

    // new_game together with lines_valid_i during ADD_SCORE.
    valid[1]  = 1'b1;
    cnt_in[1] = 3'd3;
    tick();
    valid[1] = 1'b0;
    tick();
    new_game[1] = 1'b1;
    valid[1]    = 1'b1;
    cnt_in[1]   = 3'd4;
    tick();
    new_game[1] = 1'b0;
    valid[1]    = 1'b0;
    model_reset(1);
    check_state(1, "t6");
    tick();
    check_state(1, "t6_drop");

    // Saturation at MAX_LEVEL=2.
    for (int k = 0; k < 400 && m_score[1] < 999999; k++) send(1, 3'd4, 1'b0, "t5");
    send(1, 3'd4, 1'b0, "t5_hold");
    check("t5_score_const", 32'(score[1]), 32'h999999);
    check("t5_level_const", 32'(level[1]), 32'h000002);

    // Randomized event stream on the default instance.
    do_new_game(0);
    for (int k = 0; k < 80; k++) begin
      send(0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
